// File: rtl/alu_seq_exec_if.sv
// Valid/ready bundle between the ID/EX register, the execute ALU
// and its result consumer.
interface alu_seq_exec_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            aluop;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  busy;

    modport master (
        output in_valid, aluop, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, aluop, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare, iterative shifts.
// Registered result and zero flag behind a valid/ready output.
module alu_seq_exec #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input logic           clk,
    input logic           rst,
    input logic           flush,
    alu_seq_exec_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_EQ   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_GE   = 4'b1100;
    localparam logic [3:0] OP_GEU  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b1110;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  zero_q;
    logic                  valid_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] sh_val;
    logic [3:0]            sh_op;
    logic [CW-1:0]         rem;

    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] sh_next;
    logic [CW-1:0]         shamt;
    logic [CW-1:0]         k;
    logic                  in_ready;
    logic                  accept;
    logic                  is_shift;

    assign a        = bus.op_a;
    assign b        = bus.op_b;
    assign shamt    = b[CW-1:0];
    assign is_shift = (bus.aluop == OP_SLL) ||
                      (bus.aluop == OP_SRL) ||
                      (bus.aluop == OP_SRA);
    assign in_ready = (state == IDLE) ||
                      ((state == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready && !flush;

    always_comb begin
        alu_res = a + b;
        case (bus.aluop)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SUB:  alu_res = a - b;
            OP_EQ:   alu_res = DATA_WIDTH'(a == b);
            OP_GE:   alu_res = DATA_WIDTH'($signed(a) >= $signed(b));
            OP_GEU:  alu_res = DATA_WIDTH'(a >= b);
            OP_SLT:  alu_res = DATA_WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_res = DATA_WIDTH'(a < b);
            // only zero-amount shifts complete through this path
            OP_SLL, OP_SRL, OP_SRA: alu_res = a;
            default: alu_res = a + b;
        endcase
    end

    always_comb begin
        k = (rem < STEP) ? rem : STEP;
        case (sh_op)
            OP_SRL:  sh_next = sh_val >> k;
            OP_SRA:  sh_next = $unsigned($signed(sh_val) >>> k);
            default: sh_next = sh_val << k;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            rem     <= '0;
            sh_val  <= '0;
            sh_op   <= '0;
        end else if (flush) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            rem     <= '0;
        end else if (accept) begin
            if (is_shift && (shamt != '0)) begin
                state   <= SHIFT;
                valid_q <= 1'b0;
                busy_q  <= 1'b1;
                rem     <= shamt;
                sh_val  <= a;
                sh_op   <= bus.aluop;
            end else begin
                state   <= DONE;
                valid_q <= 1'b1;
                res_q   <= alu_res;
                zero_q  <= (alu_res == '0);
            end
        end else begin
            case (state)
                SHIFT: begin
                    sh_val <= sh_next;
                    rem    <= rem - k;
                    if (rem == k) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        res_q   <= sh_next;
                        zero_q  <= (sh_next == '0);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: one DUT with 1-bit shift steps,
// one with 4-bit steps, results checked through per-DUT queues.
module tb_alu_seq_exec;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_SUM  = 4'b0010;
    localparam logic [3:0] OP_EQ   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_GE   = 4'b1100;
    localparam logic [3:0] OP_GEU  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b1110;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [32:0] q1[$];
    logic [32:0] q4[$];
    logic [31:0] last1 = '0;

    alu_seq_exec_if #(.DATA_WIDTH(32)) b1();
    alu_seq_exec_if #(.DATA_WIDTH(32)) b4();

    alu_seq_exec #(.DATA_WIDTH(32), .SHIFT_STEP(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b1.slave)
    );
    alu_seq_exec #(.DATA_WIDTH(32), .SHIFT_STEP(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b4.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        case (op)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_SUB:  return x - y;
            OP_EQ:   return (x == y) ? 32'd1 : 32'd0;
            OP_GE:   return ($signed(x) >= $signed(y)) ? 32'd1 : 32'd0;
            OP_GEU:  return (x >= y) ? 32'd1 : 32'd0;
            OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLTU: return (x < y) ? 32'd1 : 32'd0;
            default: return x + y;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic neg();
        logic [32:0] e;
        @(negedge clk);
        if (b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                chk("sb1_unexpected", 32'(b1.out_valid), 32'd0);
            end else begin
                e = q1.pop_front();
                chk("sb1_result", b1.result, e[31:0]);
                chk("sb1_zero", 32'(b1.zero), 32'(e[32]));
            end
        end
        if (b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) begin
                chk("sb4_unexpected", 32'(b4.out_valid), 32'd0);
            end else begin
                e = q4.pop_front();
                chk("sb4_result", b4.result, e[31:0]);
                chk("sb4_zero", 32'(b4.zero), 32'(e[32]));
            end
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic [3:0] op,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input bit push);
        if (w) begin
            b4.in_valid = 1'b1;
            b4.aluop = op;
            b4.op_a = x;
            b4.op_b = y;
            if (push) q4.push_back({r == 32'd0, r});
        end else begin
            b1.in_valid = 1'b1;
            b1.aluop = op;
            b1.op_a = x;
            b1.op_b = y;
            if (push) begin
                q1.push_back({r == 32'd0, r});
                last1 = r;
            end
        end
    endtask

    task automatic idle(input bit w);
        if (w) b4.in_valid = 1'b0;
        else b1.in_valid = 1'b0;
    endtask

    task automatic issue(input bit w, input logic [3:0] op,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input bit push);
        drive(w, op, x, y, r, push);
        neg();
        chk("in_ready_idle", 32'(w ? b4.in_ready : b1.in_ready), 32'd1);
        pos();
        idle(w);
    endtask

    task automatic wait_out(input bit w, output int lat, output int bsy);
        lat = 1;
        bsy = 0;
        for (int i = 0; i < 100; i++) begin
            neg();
            if (w ? b4.out_valid : b1.out_valid) break;
            if (w ? b4.busy : b1.busy) bsy++;
            lat++;
            pos();
        end
    endtask

    task automatic run(input bit w, input logic [3:0] op,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input int elat,
                       input int ebusy);
        int lat;
        int bsy;
        issue(w, op, x, y, r, 1'b1);
        wait_out(w, lat, bsy);
        chk($sformatf("latency_op%b", op), 32'(lat), 32'(elat));
        chk($sformatf("busy_cycles_op%b", op), 32'(bsy), 32'(ebusy));
        pos();
    endtask

    initial begin
        logic [3:0] sops[8];
        logic [31:0] sa;
        logic [31:0] sb;
        int lat;
        int bsy;
        int cnt;

        sops = '{OP_AND, OP_OR, OP_SUM, OP_XOR,
                 OP_SUB, OP_SLT, OP_SLTU, OP_GE};
        b1.in_valid = 1'b0; b1.aluop = '0; b1.op_a = '0; b1.op_b = '0;
        b4.in_valid = 1'b0; b4.aluop = '0; b4.op_a = '0; b4.op_b = '0;
        b1.out_ready = 1'b1;
        b4.out_ready = 1'b1;

        rst = 1'b1;
        neg(); pos();
        neg(); pos();
        rst = 1'b0;
        neg();
        chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
        chk("rst_result", b1.result, 32'd0);
        chk("rst_zero", 32'(b1.zero), 32'd1);
        chk("rst_busy", 32'(b1.busy), 32'd0);
        chk("rst_in_ready", 32'(b1.in_ready), 32'd1);
        chk("rst4_zero", 32'(b4.zero), 32'd1);
        pos();

        run(0, OP_SUM, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0);
        run(0, OP_SUB, 32'd5, 32'd5, 32'd0, 1, 0);
        run(0, OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 0);
        run(0, OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0);
        run(0, OP_EQ, 32'd3, 32'd4, 32'd0, 1, 0);
        run(0, OP_EQ, 32'd9, 32'd9, 32'd1, 1, 0);
        run(0, OP_GE, 32'd2, 32'd7, 32'd0, 1, 0);
        run(0, OP_GE, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'd1, 1, 0);
        run(0, OP_GEU, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 0);
        run(0, OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1, 0);
        run(0, OP_OR, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1, 0);
        run(0, OP_XOR, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1, 0);
        run(0, 4'b0110, 32'd5, 32'd6, 32'd11, 1, 0);
        run(0, 4'b1011, 32'hFFFFFFFF, 32'd2, 32'd1, 1, 0);

        run(0, OP_SLL, 32'h1234, 32'h20, 32'h1234, 1, 0);
        run(0, OP_SRL, 32'hF0, 32'd4, 32'h0F, 5, 4);
        run(0, OP_SRA, 32'h80000000, 32'd31, 32'hFFFFFFFF, 32, 31);
        run(0, OP_SLL, 32'h1, 32'd31, 32'h80000000, 32, 31);
        run(0, OP_SRL, 32'h80000000, 32'd31, 32'h1, 32, 31);

        run(1, OP_SLL, 32'h1, 32'd5, 32'h20, 3, 2);
        run(1, OP_SRA, 32'h80000000, 32'd7, 32'hFF000000, 3, 2);
        run(1, OP_SRL, 32'hFFFFFFFF, 32'd31, 32'h1, 9, 8);
        run(1, OP_SRL, 32'hF0, 32'd4, 32'h0F, 2, 1);

        b1.out_ready = 1'b0;
        issue(0, OP_SUM, 32'd1, 32'd2, 32'd3, 1'b1);
        wait_out(0, lat, bsy);
        chk("bp_latency", 32'(lat), 32'd1);
        pos();
        drive(0, OP_XOR, 32'hF0F0, 32'hFF, 32'hF00F, 1'b1);
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("bp_valid_held", 32'(b1.out_valid), 32'd1);
            chk("bp_result_held", b1.result, 32'd3);
            chk("bp_in_ready", 32'(b1.in_ready), 32'd0);
            pos();
        end
        b1.out_ready = 1'b1;
        neg();
        chk("bp_release_in_ready", 32'(b1.in_ready), 32'd1);
        pos();
        idle(0);
        neg();
        chk("b2b_valid", 32'(b1.out_valid), 32'd1);
        pos();

        sa = $urandom;
        sb = $urandom;
        drive(0, sops[0], sa, sb, model(sops[0], sa, sb), 1'b1);
        neg(); pos();
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) begin
                sa = $urandom;
                sb = (i == 4) ? sa : $urandom;
                drive(0, sops[i], sa, sb, model(sops[i], sa, sb), 1'b1);
            end else begin
                idle(0);
            end
            neg();
            chk($sformatf("stream_valid_%0d", i - 1),
                32'(b1.out_valid), 32'd1);
            pos();
        end
        neg();
        chk("stream_drained", 32'(b1.out_valid), 32'd0);
        pos();

        issue(0, OP_SLL, 32'h1, 32'd31, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            neg(); pos();
        end
        flush = 1'b1;
        drive(0, OP_SUM, 32'd1, 32'd1, 32'd2, 1'b0);
        neg(); pos();
        flush = 1'b0;
        idle(0);
        neg();
        chk("flush_valid", 32'(b1.out_valid), 32'd0);
        chk("flush_busy", 32'(b1.busy), 32'd0);
        chk("flush_idle", 32'(b1.in_ready), 32'd1);
        chk("flush_result_kept", b1.result, last1);
        chk("flush_zero_kept", 32'(b1.zero), 32'(last1 == 32'd0));
        pos();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            neg();
            if (b1.out_valid) cnt++;
            pos();
        end
        chk("flush_no_result", 32'(cnt), 32'd0);

        issue(0, OP_SRA, 32'h80000000, 32'd31, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            neg(); pos();
        end
        rst = 1'b1;
        neg(); pos();
        rst = 1'b0;
        neg();
        chk("rstmid_valid", 32'(b1.out_valid), 32'd0);
        chk("rstmid_result", b1.result, 32'd0);
        chk("rstmid_zero", 32'(b1.zero), 32'd1);
        chk("rstmid_busy", 32'(b1.busy), 32'd0);
        chk("rstmid_in_ready", 32'(b1.in_ready), 32'd1);
        pos();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            neg();
            if (b1.out_valid) cnt++;
            pos();
        end
        chk("rstmid_no_result", 32'(cnt), 32'd0);

        run(0, OP_SUB, 32'd10, 32'd3, 32'd7, 1, 0);

        chk("q1_empty", 32'(q1.size()), 32'd0);
        chk("q4_empty", 32'(q4.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
